dpic_mem_initiator: RTL and testbench

- Requesting side of the simulation memory port: converts pipeline load/store requests (valid/ready) into single-cycle read/write strobes on the DPI-C backed memory responder (rd_en/rd_addr/rd_data, we_en/we_addr/we_data/we_mask).
- Formats load data with sign or zero extension and returns it on a valid/ready response channel.
- Sits between the LSU stage and the memory model.
- Counts completed reads and writes for performance reporting.

---
 rtl/dpic_mem_initiator_if.sv | 46 ++++
 rtl/dpic_mem_initiator.sv | 187 ++++++++++++++++++
 tb/tb_dpic_mem_initiator.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/dpic_mem_initiator_if.sv
// Request/response and memory-strobe bundle for dpic_mem_initiator.
//   req_*  : load/store request from the LSU (valid/ready)
//   resp_* : formatted load data / refusal back to the LSU (valid/ready)
//   mem_*  : single-cycle read/write strobes to the DPI-C memory responder
// Modports:
//   master : the initiator (accepts requests, drives the memory strobes)
//   slave  : the environment (LSU and memory responder)
interface dpic_mem_initiator_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [DATA_W-1:0] req_wdata;

  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic              mem_we_en;
  logic [ADDR_W-1:0] mem_we_addr;
  logic [DATA_W-1:0] mem_we_data;
  logic [7:0]        mem_we_mask;

  modport master (
    input  req_valid, req_addr, req_we, req_size, req_unsigned, req_wdata,
    input  resp_ready, mem_rd_data,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_rd_en, mem_rd_addr, mem_we_en, mem_we_addr, mem_we_data, mem_we_mask
  );

  modport slave (
    output req_valid, req_addr, req_we, req_size, req_unsigned, req_wdata,
    output resp_ready, mem_rd_data,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_rd_en, mem_rd_addr, mem_we_en, mem_we_addr, mem_we_data, mem_we_mask
  );
endinterface

// File: rtl/dpic_mem_initiator.sv
// Requesting side of the simulation memory port.
// Turns one LSU load/store request into a single-cycle read or write strobe on
// the DPI-C memory responder, formats load data (sign/zero extension) and
// returns it on a valid/ready response channel. Misaligned requests can be
// refused without touching memory. Completed reads/writes are counted.
// Ports:
//   clock, reset  : system clock, synchronous active-high reset
//   bus (master)  : req_*/resp_* LSU handshake and mem_* responder strobes
//   perf_rd_cnt   : completed reads (wraps at 2^32)
//   perf_wr_cnt   : completed writes (wraps at 2^32)
module dpic_mem_initiator #(
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 64,
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  dpic_mem_initiator_if.master  bus,
  output logic [31:0]           perf_rd_cnt,
  output logic [31:0]           perf_wr_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t state_q, state_d;

  logic       we_q, we_d;
  logic [1:0] size_q, size_d;
  logic       uns_q, uns_d;

  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;

  logic              mem_rd_en_q, mem_rd_en_d;
  logic [ADDR_W-1:0] mem_rd_addr_q, mem_rd_addr_d;
  logic              mem_we_en_q, mem_we_en_d;
  logic [ADDR_W-1:0] mem_we_addr_q, mem_we_addr_d;
  logic [DATA_W-1:0] mem_we_data_q, mem_we_data_d;
  logic [7:0]        mem_we_mask_q, mem_we_mask_d;

  logic              rd_inc, wr_inc;
  logic [2:0]        align_mask;
  logic              misaligned;
  logic [7:0]        size_byte_mask;
  logic              sext;
  logic [DATA_W-1:0] load_ext;

  // Alignment check and byte mask for the incoming request.
  always_comb begin
    align_mask     = 3'b000;
    size_byte_mask = 8'h01;
    unique case (bus.req_size)
      2'd0: begin align_mask = 3'b000; size_byte_mask = 8'h01; end
      2'd1: begin align_mask = 3'b001; size_byte_mask = 8'h03; end
      2'd2: begin align_mask = 3'b011; size_byte_mask = 8'h0F; end
      default: begin align_mask = 3'b111; size_byte_mask = 8'hFF; end
    endcase
    misaligned = |(bus.req_addr[2:0] & align_mask);
  end

  // Load formatting from the responder's same-cycle read data.
  always_comb begin
    sext     = ~uns_q;
    load_ext = '0;
    unique case (size_q)
      2'd0: load_ext = {{56{sext & bus.mem_rd_data[7]}},  bus.mem_rd_data[7:0]};
      2'd1: load_ext = {{48{sext & bus.mem_rd_data[15]}}, bus.mem_rd_data[15:0]};
      2'd2: load_ext = {{32{sext & bus.mem_rd_data[31]}}, bus.mem_rd_data[31:0]};
      default: load_ext = bus.mem_rd_data;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    size_d       = size_q;
    uns_d        = uns_q;
    resp_valid_d = resp_valid_q;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;
    // Memory-side registers fall back to zero every cycle, so a strobe set on
    // acceptance lives for exactly the one ACCESS cycle and never repeats.
    mem_rd_en_d   = 1'b0;
    mem_rd_addr_d = '0;
    mem_we_en_d   = 1'b0;
    mem_we_addr_d = '0;
    mem_we_data_d = '0;
    mem_we_mask_d = '0;
    rd_inc        = 1'b0;
    wr_inc        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          we_d   = bus.req_we;
          size_d = bus.req_size;
          uns_d  = bus.req_unsigned;
          if (CHECK_ALIGN && misaligned) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end else begin
            state_d = ACCESS;
            if (bus.req_we) begin
              mem_we_en_d   = 1'b1;
              mem_we_addr_d = bus.req_addr;
              mem_we_data_d = bus.req_wdata;
              mem_we_mask_d = size_byte_mask;
            end else begin
              mem_rd_en_d   = 1'b1;
              mem_rd_addr_d = bus.req_addr;
            end
          end
        end
      end
      ACCESS: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_rdata_d = we_q ? '0 : load_ext;
        rd_inc       = ~we_q;
        wr_inc       = we_q;
      end
      RESP: begin
        if (bus.resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      we_q          <= 1'b0;
      size_q        <= '0;
      uns_q         <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_err_q    <= 1'b0;
      resp_rdata_q  <= '0;
      mem_rd_en_q   <= 1'b0;
      mem_rd_addr_q <= '0;
      mem_we_en_q   <= 1'b0;
      mem_we_addr_q <= '0;
      mem_we_data_q <= '0;
      mem_we_mask_q <= '0;
      perf_rd_cnt   <= '0;
      perf_wr_cnt   <= '0;
    end else begin
      state_q       <= state_d;
      we_q          <= we_d;
      size_q        <= size_d;
      uns_q         <= uns_d;
      resp_valid_q  <= resp_valid_d;
      resp_err_q    <= resp_err_d;
      resp_rdata_q  <= resp_rdata_d;
      mem_rd_en_q   <= mem_rd_en_d;
      mem_rd_addr_q <= mem_rd_addr_d;
      mem_we_en_q   <= mem_we_en_d;
      mem_we_addr_q <= mem_we_addr_d;
      mem_we_data_q <= mem_we_data_d;
      mem_we_mask_q <= mem_we_mask_d;
      perf_rd_cnt   <= perf_rd_cnt + 32'(rd_inc);
      perf_wr_cnt   <= perf_wr_cnt + 32'(wr_inc);
    end
  end

  assign bus.req_ready   = (state_q == IDLE);
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_err    = resp_err_q;
  assign bus.resp_rdata  = resp_rdata_q;
  assign bus.mem_rd_en   = mem_rd_en_q;
  assign bus.mem_rd_addr = mem_rd_addr_q;
  assign bus.mem_we_en   = mem_we_en_q;
  assign bus.mem_we_addr = mem_we_addr_q;
  assign bus.mem_we_data = mem_we_data_q;
  assign bus.mem_we_mask = mem_we_mask_q;

endmodule

// File: tb/tb_dpic_mem_initiator.sv
// Directed self-checking bench for dpic_mem_initiator with a small byte
// memory standing in for the DPI-C responder (combinational read, write on
// the clock edge while mem_we_en is high).
module tb_dpic_mem_initiator;

  logic        clock;
  logic        reset;
  logic [31:0] perf_rd_cnt;
  logic [31:0] perf_wr_cnt;

  int tests = 0;
  int fails = 0;
  int rd_strobes = 0;
  int wr_strobes = 0;

  dpic_mem_initiator_if #(.ADDR_W(64), .DATA_W(64)) bus ();

  dpic_mem_initiator #(
    .ADDR_W(64),
    .DATA_W(64),
    .CHECK_ALIGN(1'b1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus),
    .perf_rd_cnt(perf_rd_cnt),
    .perf_wr_cnt(perf_wr_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Responder memory: 64 bytes, indexed by the low address bits.
  logic [7:0] tbmem [64] = '{0: 8'h34, 1: 8'h92, 3: 8'hF0, default: 8'h00};

  always_comb begin
    bus.mem_rd_data = '0;
    if (bus.mem_rd_en)
      for (int i = 0; i < 8; i++)
        bus.mem_rd_data[8*i +: 8] = tbmem[(int'(bus.mem_rd_addr[5:0]) + i) % 64];
  end

  always @(posedge clock) begin
    if (bus.mem_rd_en) rd_strobes <= rd_strobes + 1;
    if (bus.mem_we_en) begin
      wr_strobes <= wr_strobes + 1;
      for (int i = 0; i < 8; i++)
        if (bus.mem_we_mask[i])
          tbmem[(int'(bus.mem_we_addr[5:0]) + i) % 64] <= bus.mem_we_data[8*i +: 8];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a request at a falling edge; returns one cycle after acceptance.
  task automatic issue(input logic [63:0] addr, input logic we, input logic [1:0] size,
                       input logic uns, input logic [63:0] wdata);
    bus.req_valid    = 1'b1;
    bus.req_addr     = addr;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_wdata    = wdata;
    @(negedge clock);
    bus.req_valid = 1'b0;
  endtask

  task automatic handshake();
    bus.resp_ready = 1'b1;
    @(negedge clock);
    bus.resp_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  logic [63:0] held;
  int rs0, ws0;

  initial begin
    reset = 1'b1;
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_we = 1'b0; bus.req_size = '0;
    bus.req_unsigned = 1'b0; bus.req_wdata = '0; bus.resp_ready = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // Reset state
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_resp_rdata", bus.resp_rdata, 0);
    chk("rst_resp_err", bus.resp_err, 0);
    chk("rst_mem_rd_en", bus.mem_rd_en, 0);
    chk("rst_mem_we_en", bus.mem_we_en, 0);
    chk("rst_mem_we_mask", bus.mem_we_mask, 0);
    chk("rst_perf_rd", perf_rd_cnt, 0);
    chk("rst_perf_wr", perf_wr_cnt, 0);

    // Signed byte load
    issue(64'h8000_0003, 1'b0, 2'd0, 1'b0, '0);
    chk("lb_rd_en", bus.mem_rd_en, 1);
    chk("lb_rd_addr", bus.mem_rd_addr, 64'h8000_0003);
    chk("lb_req_ready", bus.req_ready, 0);
    chk("lb_valid_early", bus.resp_valid, 0);
    @(negedge clock);
    chk("lb_valid", bus.resp_valid, 1);
    chk("lb_rdata", bus.resp_rdata, 64'hFFFF_FFFF_FFFF_FFF0);
    chk("lb_err", bus.resp_err, 0);
    chk("lb_rd_en_off", bus.mem_rd_en, 0);
    chk("lb_rd_addr_off", bus.mem_rd_addr, 0);
    chk("lb_strobes", rd_strobes, 1);
    chk("lb_perf_rd", perf_rd_cnt, 1);
    handshake();
    chk("lb_valid_clr", bus.resp_valid, 0);
    chk("lb_ready_back", bus.req_ready, 1);

    // Word store
    issue(64'h8000_0010, 1'b1, 2'd2, 1'b0, 64'h1122_3344_5566_7788);
    chk("sw_we_en", bus.mem_we_en, 1);
    chk("sw_we_addr", bus.mem_we_addr, 64'h8000_0010);
    chk("sw_we_data", bus.mem_we_data, 64'h1122_3344_5566_7788);
    chk("sw_we_mask", bus.mem_we_mask, 8'h0F);
    chk("sw_rd_en", bus.mem_rd_en, 0);
    @(negedge clock);
    chk("sw_valid", bus.resp_valid, 1);
    chk("sw_rdata", bus.resp_rdata, 0);
    chk("sw_we_off", bus.mem_we_en, 0);
    chk("sw_we_mask_off", bus.mem_we_mask, 0);
    chk("sw_strobes", wr_strobes, 1);
    chk("sw_perf_wr", perf_wr_cnt, 1);
    handshake();

    // Read-backs: unsigned word, full doubleword, signed halfword
    issue(64'h8000_0010, 1'b0, 2'd2, 1'b1, '0);
    @(negedge clock);
    chk("lwu_rdata", bus.resp_rdata, 64'h0000_0000_5566_7788);
    handshake();
    issue(64'h8000_0010, 1'b0, 2'd3, 1'b0, '0);
    @(negedge clock);
    chk("ld_rdata", bus.resp_rdata, 64'h0000_0000_5566_7788);
    handshake();
    issue(64'h8000_0000, 1'b0, 2'd1, 1'b0, '0);
    @(negedge clock);
    chk("lh_rdata", bus.resp_rdata, 64'hFFFF_FFFF_FFFF_9234);
    chk("lh_perf_rd", perf_rd_cnt, 4);
    handshake();

    // Misaligned word: refused, no strobe, counters unchanged
    rs0 = rd_strobes; ws0 = wr_strobes;
    issue(64'h8000_0002, 1'b0, 2'd2, 1'b0, '0);
    chk("mis_valid", bus.resp_valid, 1);
    chk("mis_err", bus.resp_err, 1);
    chk("mis_rdata", bus.resp_rdata, 0);
    chk("mis_rd_en", bus.mem_rd_en, 0);
    chk("mis_we_en", bus.mem_we_en, 0);
    handshake();
    chk("mis_rd_strobes", rd_strobes, 64'(rs0));
    chk("mis_wr_strobes", wr_strobes, 64'(ws0));
    chk("mis_perf_rd", perf_rd_cnt, 4);
    chk("mis_perf_wr", perf_wr_cnt, 1);

    // Backpressure with a competing request held on req_valid
    issue(64'h8000_0003, 1'b0, 2'd0, 1'b0, '0);
    @(negedge clock);
    held = bus.resp_rdata;
    chk("bp_first_rdata", held, 64'hFFFF_FFFF_FFFF_FFF0);
    rs0 = rd_strobes; ws0 = wr_strobes;
    bus.req_valid = 1'b1; bus.req_addr = 64'h8000_0020; bus.req_we = 1'b1;
    bus.req_size = 2'd3; bus.req_wdata = 64'hDEAD_BEEF_0BAD_F00D;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      chk("bp_valid", bus.resp_valid, 1);
      chk("bp_rdata", bus.resp_rdata, 64'hFFFF_FFFF_FFFF_FFF0);
      chk("bp_req_ready", bus.req_ready, 0);
      chk("bp_we_en", bus.mem_we_en, 0);
    end
    chk("bp_rd_strobes", rd_strobes, 64'(rs0));
    chk("bp_wr_strobes", wr_strobes, 64'(ws0));
    bus.resp_ready = 1'b1;
    @(negedge clock);
    bus.resp_ready = 1'b0;
    chk("bp_valid_clr", bus.resp_valid, 0);
    chk("bp_ready_back", bus.req_ready, 1);
    chk("bp_not_yet", bus.mem_we_en, 0);
    @(negedge clock);
    bus.req_valid = 1'b0;
    chk("bp_store_en", bus.mem_we_en, 1);
    chk("bp_store_mask", bus.mem_we_mask, 8'hFF);
    chk("bp_store_data", bus.mem_we_data, 64'hDEAD_BEEF_0BAD_F00D);
    @(negedge clock);
    chk("bp_perf_rd", perf_rd_cnt, 5);
    chk("bp_perf_wr", perf_wr_cnt, 2);
    handshake();

    // Reset in the strobe cycle
    issue(64'h8000_0008, 1'b0, 2'd3, 1'b0, '0);
    chk("ra_rd_en", bus.mem_rd_en, 1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("ra_rd_en_off", bus.mem_rd_en, 0);
    chk("ra_rd_addr_off", bus.mem_rd_addr, 0);
    chk("ra_valid", bus.resp_valid, 0);
    chk("ra_req_ready", bus.req_ready, 1);
    chk("ra_perf_rd", perf_rd_cnt, 0);
    chk("ra_perf_wr", perf_wr_cnt, 0);
    @(negedge clock);
    chk("ra_valid_later", bus.resp_valid, 0);

    // Counter wrap from a preloaded all-ones value
    force dut.perf_rd_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.perf_rd_cnt;
    @(negedge clock);
    issue(64'h8000_0003, 1'b0, 2'd0, 1'b1, '0);
    @(negedge clock);
    chk("wrap_rdata", bus.resp_rdata, 64'h0000_0000_0000_00F0);
    chk("wrap_perf_rd", perf_rd_cnt, 0);
    chk("wrap_perf_wr", perf_wr_cnt, 0);
    handshake();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
